// File: rtl/sha3_scan_dispatcher_if.sv
// Handshake bundle between the scan dispatcher, the hash pipe and the hit consumer.
// master = dispatcher side; slave = pipe/consumer side.
interface sha3_scan_dispatcher_if;
  logic        pipe_gimme;
  logic        pipe_sample;
  logic [31:0] pipe_nonce;
  logic        pipe_good;
  logic [63:0] pipe_hash;
  logic        found_valid;
  logic        found_ready;
  logic [31:0] found_nonce;

  modport master (
    input  pipe_gimme,
    input  pipe_good,
    input  pipe_hash,
    input  found_ready,
    output pipe_sample,
    output pipe_nonce,
    output found_valid,
    output found_nonce
  );

  modport slave (
    output pipe_gimme,
    output pipe_good,
    output pipe_hash,
    output found_ready,
    input  pipe_sample,
    input  pipe_nonce,
    input  found_valid,
    input  found_nonce
  );
endinterface

// File: rtl/sha3_scan_dispatcher.sv
// Nonce scan dispatcher: feeds consecutive nonces to a hash pipe, tracks in-flight tags, reports hits.
// Optional statistics counters are built when SHA3_SCAN_STATS_EN is defined.
module sha3_scan_dispatcher #(
  parameter int FIFO_DEPTH  = 32,
  parameter int FLUSH_QUIET = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] base_nonce,
  input  logic [31:0] nonce_count,
  input  logic [63:0] threshold,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [31:0] stat_hashes,
  output logic [31:0] stat_hits,
  sha3_scan_dispatcher_if.master bus
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int QUIET_W = (FLUSH_QUIET > 1) ? $clog2(FLUSH_QUIET + 1) : 1;
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(FLUSH_QUIET - 1);

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_t;

  state_t state_reg, state_next;
  logic   done_reg, done_next;

  logic [QUIET_W-1:0] quiet_cnt_reg;

  logic [31:0] nonce_reg;
  logic [31:0] remaining_reg;
  logic [63:0] threshold_reg;
  logic        aborted_reg;

  // Tag = {valid, nonce}; head is read combinationally so it meets pipe_hash on the pipe_good cycle.
  logic [32:0]      tag_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] fifo_cnt_reg;

  logic        found_valid_reg;
  logic [31:0] found_nonce_reg;
  logic        overflow_reg;

  logic        start_fire;
  logic        issue_valid;
  logic        pipe_sample;
  logic        push;
  logic        pop;
  logic        fifo_empty;
  logic [32:0] head_tag;
  logic        valid_pop;
  logic        hit;

  assign start_fire  = (state_reg == ST_IDLE) && start;
  // Abort takes effect on the very slot issued in the abort cycle.
  assign issue_valid = (remaining_reg != 32'd0) && !aborted_reg && !abort;
  assign pipe_sample = (state_reg == ST_ISSUE) && bus.pipe_gimme;
  assign push        = pipe_sample;
  assign fifo_empty  = (fifo_cnt_reg == '0);
  assign pop         = bus.pipe_good && !fifo_empty && (state_reg != ST_FLUSH);
  assign head_tag    = tag_mem[rd_ptr_reg];
  assign valid_pop   = pop && head_tag[32];
  assign hit         = valid_pop && (bus.pipe_hash < threshold_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FLUSH;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_FLUSH: begin
        if (!bus.pipe_good && (quiet_cnt_reg == QUIET_LAST))
          state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (start)
          state_next = (nonce_count == 32'd0) ? ST_DRAIN : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!issue_valid && !bus.pipe_gimme)
          state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty && !pop) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_FLUSH;
    endcase
  end

  // The pipe has no reset, so results still in flight after rst must drain out unseen.
  always_ff @(posedge clk) begin
    if (rst) begin
      quiet_cnt_reg <= '0;
    end else if (state_reg == ST_FLUSH) begin
      if (bus.pipe_good)
        quiet_cnt_reg <= '0;
      else if (quiet_cnt_reg != QUIET_LAST)
        quiet_cnt_reg <= quiet_cnt_reg + QUIET_W'(1);
    end else begin
      quiet_cnt_reg <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nonce_reg     <= '0;
      remaining_reg <= '0;
      threshold_reg <= '0;
      aborted_reg   <= 1'b0;
    end else if (start_fire) begin
      nonce_reg     <= base_nonce;
      remaining_reg <= nonce_count;
      threshold_reg <= threshold;
      aborted_reg   <= 1'b0;
    end else if (state_reg == ST_ISSUE) begin
      if (abort)
        aborted_reg <= 1'b1;
      if (pipe_sample && issue_valid) begin
        nonce_reg     <= nonce_reg + 32'd1;
        remaining_reg <= remaining_reg - 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr_reg] <= {issue_valid, nonce_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // A single holding slot: a hit arriving while it is occupied and not being taken is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      found_valid_reg <= 1'b0;
      found_nonce_reg <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      if (hit) begin
        if (!found_valid_reg || bus.found_ready) begin
          found_valid_reg <= 1'b1;
          found_nonce_reg <= head_tag[31:0];
        end else begin
          overflow_reg <= 1'b1;
        end
      end else if (found_valid_reg && bus.found_ready) begin
        found_valid_reg <= 1'b0;
      end
      if (start_fire)
        overflow_reg <= 1'b0;
    end
  end

`ifdef SHA3_SCAN_STATS_EN
  logic [31:0] stat_hashes_reg, stat_hits_reg;

  always_ff @(posedge clk) begin
    if (rst || start_fire) begin
      stat_hashes_reg <= '0;
      stat_hits_reg   <= '0;
    end else begin
      if (valid_pop && (stat_hashes_reg != 32'hFFFF_FFFF))
        stat_hashes_reg <= stat_hashes_reg + 32'd1;
      if (hit && (stat_hits_reg != 32'hFFFF_FFFF))
        stat_hits_reg <= stat_hits_reg + 32'd1;
    end
  end

  assign stat_hashes = stat_hashes_reg;
  assign stat_hits   = stat_hits_reg;
`else
  assign stat_hashes = 32'd0;
  assign stat_hits   = 32'd0;
`endif

  assign bus.pipe_sample = pipe_sample;
  assign bus.pipe_nonce  = nonce_reg;
  assign bus.found_valid = found_valid_reg;
  assign bus.found_nonce = found_nonce_reg;
  assign busy            = (state_reg != ST_IDLE);
  assign done            = done_reg;
  assign overflow        = overflow_reg;

endmodule

// File: doc/sha3_scan_dispatcher.md
SHA3_SCAN_DISPATCHER -- requirements
Module: sha3_scan_dispatcher

Interface
REQ-001 Parameter: FIFO_DEPTH, default 32, depth of the in-flight tag FIFO; must be >= 32.
REQ-002 Parameter: FLUSH_QUIET, default 64, count of consecutive cycles with no pipe_good required before leaving FLUSH.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  pulse that begins a scan; honoured only in IDLE.
REQ-006 abort  in  1  pulse that stops issuing new nonces.
REQ-007 base_nonce  in  32  first nonce of the scan.
REQ-008 nonce_count  in  32  number of nonces to scan.
REQ-009 threshold  in  64  hash word must be strictly below this value to count as a hit.
REQ-010 pipe_gimme  in  1  hash pipe can accept input.
REQ-011 pipe_sample  out  1  slot issued to the hash pipe this cycle.
REQ-012 pipe_nonce  out  32  nonce for the issued slot.
REQ-013 pipe_good  in  1  hash pipe result valid, results returned in issue order.
REQ-014 pipe_hash  in  64  compared word of the final hash.
REQ-015 busy  out  1  state is not IDLE.
REQ-016 done  out  1  one-cycle pulse on the return to IDLE after a scan or abort.
REQ-017 found_valid/found_ready  out/in  1/1  handshake for a hit.
REQ-018 found_nonce  out  32  nonce of the held hit.
REQ-019 overflow  out  1  sticky flag: a hit was lost because found was still occupied.
REQ-020 stat_hashes/stat_hits  out  32/32  statistics counters (see Configuration).

Function
REQ-021 States SHALL be FLUSH, IDLE, ISSUE, DRAIN.
REQ-022 FLUSH SHALL exit to IDLE after FLUSH_QUIET consecutive cycles with pipe_good low; pipe_good during FLUSH SHALL restart the count and SHALL be discarded.
REQ-023 On start in IDLE, the block SHALL latch base_nonce, nonce_count and threshold and clear overflow.
REQ-024 On start in IDLE with nonce_count=0, the block SHALL go to DRAIN.
REQ-025 On start in IDLE with any other nonce_count, the block SHALL go to ISSUE.
REQ-026 In ISSUE, pipe_sample SHALL equal pipe_gimme.
REQ-027 Each pipe_sample cycle SHALL push the tag {valid, nonce} into the FIFO.
REQ-028 Valid slots SHALL carry consecutive nonces base, base+1, ..., with arithmetic modulo 2^32 (wrap allowed).
REQ-029 Once the remaining count is 0, or after abort, slots issued to finish the current pipe burst SHALL carry valid=0.
REQ-030 When the remaining count is 0 (or after abort) and pipe_gimme is low, ISSUE SHALL go to DRAIN.
REQ-031 DRAIN SHALL go to IDLE, with done pulsed in the same cycle, once the FIFO is empty and no pop is occurring.
REQ-032 Each pipe_good SHALL pop one tag.
REQ-033 A hit is a popped tag with valid=1 and pipe_hash < threshold (unsigned).
REQ-034 Push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-035 pipe_good while the FIFO is empty outside FLUSH SHALL be ignored.
REQ-036 FIFO full SHALL never occur, because the pipe burst is at most 26 slots.
REQ-037 A hit with found_valid low, or with found_valid and found_ready both high, SHALL load found_nonce and set found_valid on the next cycle.
REQ-038 A hit with found_valid high and found_ready low SHALL be dropped and SHALL set overflow.
REQ-039 found_valid SHALL drop on the cycle after the handshake unless it is reloaded.
REQ-040 abort in IDLE or FLUSH SHALL be ignored.
REQ-041 abort and start in the same cycle in IDLE SHALL be treated as start only.
REQ-042 Latency from issue to hit report SHALL be the pipe latency plus 1 cycle.

Reset
REQ-043 rst SHALL force state FLUSH, empty the FIFO and zero the counters.
REQ-044 rst SHALL clear pipe_sample, busy=1, done, found_valid, found_nonce and overflow.
REQ-045 rst mid-scan SHALL discard all in-flight results through FLUSH, because the pipe has no reset.

Configuration
REQ-046 With SHA3_SCAN_STATS_EN defined, stat_hashes SHALL count valid pops and stat_hits SHALL count hits, both cleared on start, saturating at 0xFFFFFFFF.
REQ-047 Without SHA3_SCAN_STATS_EN, stat_hashes and stat_hits SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-048 rst, then pipe_good pulses at cycles 10 and 40 -> IDLE entered exactly 64 cycles after cycle 40; no found_valid.
REQ-049 base=0xFFFFFFFE, count=4, threshold=max, model pipe with a 26-slot burst -> nonces FFFFFFFE, FFFFFFFF, 0, 1 valid; 22 dummy slots; 4 hits in order; done once.
REQ-050 count=0 start -> no pipe_sample, done 2 cycles after start.
REQ-051 Two hits on consecutive pops with found_ready=0 -> first nonce held, overflow=1; with the macro defined, stat_hits=2.
REQ-052 abort 5 slots into a count=1000 scan -> remaining burst slots tagged invalid, no further bursts, done after drain, hashes counted=5.
